// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (IR/PC/exc/BD/payload) with flush, stall, bubble and perf counters; 1-cycle latency.
// Backpressure: flush > m_stall (hold) > stall (hold or bubble) > load; no combinational input->output path.
module pipe_stage_reg #(
    parameter int unsigned DW              = 64,
    parameter logic [31:0] RESET_PC        = 32'h0000_3000,
    parameter bit          BUBBLE_ON_STALL = 1'b0,
    parameter bit          CLEAR_IR_ON_EXC = 1'b1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [31:0]      flush_pc,
    input  logic             stall,
    input  logic             m_stall,
    input  logic             in_valid,
    input  logic [31:0]      in_ir,
    input  logic [31:0]      in_pc,
    input  logic [4:0]       in_exc,
    input  logic             in_bd,
    input  logic [DW-1:0]    in_data,
    input  logic [4:0]       local_exc,
    output logic             out_valid,
    output logic [31:0]      out_ir,
    output logic [31:0]      out_pc,
    output logic [4:0]       out_exc,
    output logic             out_bd,
    output logic [DW-1:0]    out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } act_e;

    act_e             act;
    logic [4:0]       merged_exc;
    logic [31:0]      load_ir;

    logic             valid_q, valid_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      pc_q, pc_d;
    logic [4:0]       exc_q, exc_d;
    logic             bd_q, bd_d;
    logic [DW-1:0]    data_q, data_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        act = ACT_LOAD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (m_stall) begin
            act = ACT_HOLD;
        end else if (stall) begin
            act = BUBBLE_ON_STALL ? ACT_BUBBLE : ACT_HOLD;
        end
    end

    // Upstream exception is older, so it wins; a local fault only counts for a real instruction.
    always_comb begin
        merged_exc = 5'd0;
        if (in_exc != 5'd0) begin
            merged_exc = in_exc;
        end else if (in_valid) begin
            merged_exc = local_exc;
        end
        load_ir = in_ir;
        if (!in_valid || (CLEAR_IR_ON_EXC && (merged_exc != 5'd0))) begin
            load_ir = 32'd0;
        end
    end

    always_comb begin
        valid_d = valid_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        data_d  = data_q;
        case (act)
            ACT_FLUSH: begin
                valid_d = 1'b0;
                ir_d    = 32'd0;
                pc_d    = flush_pc;
                exc_d   = 5'd0;
                bd_d    = 1'b0;
                data_d  = '0;
            end
            // Bubble keeps PC/BD of the stalled instruction so an interrupt here still gets the right EPC.
            ACT_BUBBLE: begin
                valid_d = 1'b0;
                ir_d    = 32'd0;
                pc_d    = in_pc;
                exc_d   = 5'd0;
                bd_d    = in_bd;
                data_d  = '0;
            end
            ACT_LOAD: begin
                valid_d = in_valid;
                ir_d    = load_ir;
                pc_d    = in_pc;
                exc_d   = merged_exc;
                bd_d    = in_bd;
                data_d  = in_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (((act == ACT_HOLD) || (act == ACT_BUBBLE)) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((act == ACT_FLUSH) && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            ir_q        <= 32'd0;
            pc_q        <= RESET_PC;
            exc_q       <= 5'd0;
            bd_q        <= 1'b0;
            data_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            exc_q       <= exc_d;
            bd_q        <= bd_d;
            data_q      <= data_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_ir    = ir_q;
    assign out_pc    = pc_q;
    assign out_exc   = exc_q;
    assign out_bd    = bd_q;
    assign out_data  = data_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
